svnet_fifo_packer: RTL and testbench



---
 rtl/svnet_fifo_packer_pkg.sv | 27 ++
 rtl/svnet_fifo_packer_if.sv | 38 +++
 rtl/svnet_fifo_packer.sv | 125 ++++++++++++
 tb/tb_svnet_fifo_packer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/svnet_fifo_packer_pkg.sv
// Shared definitions for the FIFO-to-FIFO width packer.
// Provides the lane/count width helpers, the fill-to-write latency constant and
// an instantiation macro that declares the bus interface plus the packer
// (expects clk and rst to be in scope at the point of use).
package svnet_fifo_packer_pkg;

  // Cycles from the completing input pop to the earliest downstream write.
  localparam int unsigned SVNET_FIFO_PACKER_LATENCY = 1;

  // Width of the valid-lane count: a lane index plus one, never overflows.
  function automatic int unsigned packer_count_width(input int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

  // Width of the lane pointer, at least one bit so RATIO == 1 stays legal.
  function automatic int unsigned packer_lane_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

`define SVNET_FIFO_PACKER(name, in_depth, out_depth) \
  if (1) begin : name \
    svnet_fifo_packer_if #(.IN_DEPTH(in_depth), .OUT_DEPTH(out_depth)) bus (); \
    svnet_fifo_packer #(.IN_DEPTH(in_depth), .OUT_DEPTH(out_depth)) u_packer ( \
      .clk (clk), .rst (rst), .bus (bus.master)); \
  end

// File: rtl/svnet_fifo_packer_if.sv
// Bus between the upstream FIFO read port, the packer and the downstream FIFO
// write port.
//   in_used_space / in_read_data / in_read : upstream FIFO read side
//   out_free_space / out_write*            : downstream FIFO write side
// master = the packer, slave = the surrounding FIFOs.
interface svnet_fifo_packer_if
  import svnet_fifo_packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned IN_DEPTH  = 16,
  parameter int unsigned OUT_DEPTH = 16
);
  localparam int unsigned UW = $clog2(IN_DEPTH) + 1;
  localparam int unsigned FW = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned CW = packer_count_width(RATIO);
  localparam int unsigned DW = RATIO * IN_WIDTH;

  logic [UW-1:0]     in_used_space;
  logic [IN_WIDTH:0] in_read_data;
  logic              in_read;
  logic [FW-1:0]     out_free_space;
  logic              out_write;
  logic [DW-1:0]     out_write_data;
  logic [CW-1:0]     out_write_count;
  logic              out_write_last;

  modport master (
    input  in_used_space, in_read_data, out_free_space,
    output in_read, out_write, out_write_data, out_write_count, out_write_last
  );

  modport slave (
    output in_used_space, in_read_data, out_free_space,
    input  in_read, out_write, out_write_data, out_write_count, out_write_last
  );

endinterface

// File: rtl/svnet_fifo_packer.sv
// Packs RATIO narrow words (each with a last flag) popped from an upstream FIFO
// into one wide word pushed to a downstream FIFO. A last flag closes a partial
// word early; unfilled lanes are zero. A one-deep hold register decouples the
// accumulator from downstream back-pressure.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - svnet_fifo_packer_if.master (upstream read + downstream write)
module svnet_fifo_packer
  import svnet_fifo_packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned IN_DEPTH  = 16,
  parameter int unsigned OUT_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  svnet_fifo_packer_if.master bus
);

  localparam int unsigned LW = packer_lane_width(RATIO);
  localparam int unsigned CW = packer_count_width(RATIO);
  localparam int unsigned DW = RATIO * IN_WIDTH;

  logic [LW-1:0]       lane_q, lane_d;
  logic [DW-1:0]       acc_q, acc_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DW-1:0]       hold_data_q, hold_data_d;
  logic [CW-1:0]       hold_count_q, hold_count_d;
  logic                hold_last_q, hold_last_d;

  logic                in_last_c;
  logic [IN_WIDTH-1:0] in_payload_c;
  logic                completes_c;
  logic                rd_c;
  logic                wr_c;
  logic [DW-1:0]       merged_c;

  assign in_last_c    = bus.in_read_data[IN_WIDTH];
  assign in_payload_c = bus.in_read_data[IN_WIDTH-1:0];
  assign completes_c  = (lane_q == LW'(RATIO - 1)) || in_last_c;

  // Drain and pop are combinational so a drain frees the hold for a refill in
  // the same cycle; both are held low while reset is asserted.
  assign wr_c = !rst && hold_valid_q && (bus.out_free_space != '0);
  assign rd_c = !rst && (bus.in_used_space != '0) &&
                (!completes_c || !hold_valid_q || wr_c);

  assign bus.in_read         = rd_c;
  assign bus.out_write       = wr_c;
  assign bus.out_write_data  = hold_data_q;
  assign bus.out_write_count = hold_count_q;
  assign bus.out_write_last  = hold_last_q;

  // Accumulator with the incoming payload placed in the current lane; lanes
  // above the current one are forced to zero.
  always_comb begin
    merged_c = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (LW'(i) < lane_q) begin
        merged_c[i*IN_WIDTH +: IN_WIDTH] = acc_q[i*IN_WIDTH +: IN_WIDTH];
      end else if (LW'(i) == lane_q) begin
        merged_c[i*IN_WIDTH +: IN_WIDTH] = in_payload_c;
      end
    end
  end

  // Next-state for lane pointer, accumulator and hold register.
  always_comb begin
    lane_d       = lane_q;
    acc_d        = acc_q;
    hold_valid_d = hold_valid_q && !wr_c;
    hold_data_d  = hold_data_q;
    hold_count_d = hold_count_q;
    hold_last_d  = hold_last_q;
    if (rd_c) begin
      if (completes_c) begin
        hold_valid_d = 1'b1;
        hold_data_d  = merged_c;
        hold_count_d = CW'(lane_q) + CW'(1);
        hold_last_d  = in_last_c;
        lane_d       = '0;
        acc_d        = '0;
      end else begin
        lane_d = lane_q + LW'(1);
        acc_d  = merged_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q       <= '0;
      acc_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_count_q <= '0;
      hold_last_q  <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_count_q <= hold_count_d;
      hold_last_q  <= hold_last_d;
    end
  end

  a_read_has_data: assert property (@(posedge clk) disable iff (rst)
    bus.in_read |-> (bus.in_used_space != '0));

  a_write_has_space: assert property (@(posedge clk) disable iff (rst)
    bus.out_write |-> (bus.out_free_space != '0));

  a_write_count_range: assert property (@(posedge clk) disable iff (rst)
    bus.out_write |-> ((bus.out_write_count >= CW'(1)) &&
                       (bus.out_write_count <= CW'(RATIO))));

  // A partial word left in the accumulator at the end is a lost packet tail.
  final begin
    a_no_partial_pending: assert (lane_q == '0);
  end

endmodule

// File: tb/tb_svnet_fifo_packer.sv
// Directed bench for svnet_fifo_packer: a RATIO=4 x 8-bit instance and a
// RATIO=1 x 16-bit instance, each fed from a queue modelling the upstream FIFO.
module tb_svnet_fifo_packer;
  import svnet_fifo_packer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  svnet_fifo_packer_if #(.IN_WIDTH(8),  .RATIO(4), .IN_DEPTH(16), .OUT_DEPTH(16)) bus4 ();
  svnet_fifo_packer_if #(.IN_WIDTH(16), .RATIO(1), .IN_DEPTH(16), .OUT_DEPTH(16)) bus1 ();

  svnet_fifo_packer #(.IN_WIDTH(8), .RATIO(4), .IN_DEPTH(16), .OUT_DEPTH(16)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4.master));
  svnet_fifo_packer #(.IN_WIDTH(16), .RATIO(1), .IN_DEPTH(16), .OUT_DEPTH(16)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.master));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [8:0]  q4[$];
  logic [16:0] q1[$];
  int free4 = 16;
  int free1 = 16;
  bit stall1 = 1'b0;

  logic [31:0] w4_d[$];
  logic [2:0]  w4_c[$];
  logic        w4_l[$];
  int          w4_cyc[$];
  int rd4_cnt = 0;
  int rd4_first = -1;
  int rd4_last = -1;

  logic [15:0] w1_d[$];
  logic [0:0]  w1_c[$];
  logic        w1_l[$];
  int          w1_cyc[$];
  int          r1_cyc[$];
  logic [15:0] exp1[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    bus4.in_used_space  = 5'((q4.size() > 16) ? 16 : q4.size());
    bus4.in_read_data   = (q4.size() > 0) ? q4[0] : 9'h0;
    bus4.out_free_space = 5'(free4);
    bus1.in_used_space  = (stall1 || q1.size() == 0) ? 5'd0 :
                          5'((q1.size() > 16) ? 16 : q1.size());
    bus1.in_read_data   = (q1.size() > 0) ? q1[0] : 17'h0;
    bus1.out_free_space = 5'(free1);
  endtask

  // One clock: sample handshakes mid-cycle, then apply pops/pushes after the edge.
  task automatic tick();
    logic r4, wr4, r1, wr1, l4, l1;
    logic [31:0] d4;
    logic [2:0]  c4;
    logic [15:0] d1;
    logic [0:0]  c1;
    @(negedge clk);
    r4 = bus4.in_read;  wr4 = bus4.out_write;
    d4 = bus4.out_write_data; c4 = bus4.out_write_count; l4 = bus4.out_write_last;
    r1 = bus1.in_read;  wr1 = bus1.out_write;
    d1 = bus1.out_write_data; c1 = bus1.out_write_count; l1 = bus1.out_write_last;
    @(posedge clk);
    #1;
    if (r4 && q4.size() > 0) begin
      void'(q4.pop_front());
      rd4_cnt++;
      if (rd4_first < 0) rd4_first = cyc;
      rd4_last = cyc;
    end
    if (wr4) begin
      w4_d.push_back(d4); w4_c.push_back(c4); w4_l.push_back(l4); w4_cyc.push_back(cyc);
    end
    if (r1 && q1.size() > 0) begin
      void'(q1.pop_front());
      r1_cyc.push_back(cyc);
    end
    if (wr1) begin
      w1_d.push_back(d1); w1_c.push_back(c1); w1_l.push_back(l1); w1_cyc.push_back(cyc);
    end
    cyc++;
    refresh();
  endtask

  task automatic push4(input logic [7:0] d, input logic last);
    q4.push_back({last, d});
    refresh();
  endtask

  task automatic clear_rd4();
    rd4_cnt = 0; rd4_first = -1; rd4_last = -1;
  endtask

  task automatic run4(input string tag, input int n, input int budget);
    int k = 0;
    while (w4_d.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_nwrites"}, 64'(w4_d.size()), 64'(n));
  endtask

  task automatic expect4(input string tag, input logic [31:0] d, input logic [2:0] c, input logic l);
    chk({tag, "_present"}, 64'(w4_d.size() > 0), 64'(1));
    if (w4_d.size() > 0) begin
      chk({tag, "_data"},  64'(w4_d.pop_front()), 64'(d));
      chk({tag, "_count"}, 64'(w4_c.pop_front()), 64'(c));
      chk({tag, "_last"},  64'(w4_l.pop_front()), 64'(l));
      void'(w4_cyc.pop_front());
    end
  endtask

  initial begin
    refresh();
    repeat (3) tick();
    chk("rst_in_read",   64'(bus4.in_read),         64'(0));
    chk("rst_out_write", 64'(bus4.out_write),       64'(0));
    chk("rst_data",      64'(bus4.out_write_data),  64'(0));
    chk("rst_count",     64'(bus4.out_write_count), 64'(0));
    chk("rst_last",      64'(bus4.out_write_last),  64'(0));
    chk("rst_r1_write",  64'(bus1.out_write),       64'(0));
    rst = 1'b0;
    refresh();
    tick();

    // Two full words, one pop per cycle.
    clear_rd4();
    for (int i = 1; i <= 8; i++) push4(8'(i), i == 8);
    run4("full", 2, 40);
    chk("full_reads", 64'(rd4_cnt), 64'(8));
    chk("full_span",  64'(rd4_last - rd4_first), 64'(7));
    expect4("full_w0", 32'h04030201, 3'd4, 1'b0);
    expect4("full_w1", 32'h08070605, 3'd4, 1'b1);

    // Short packet closed by last.
    push4(8'hA1, 1'b0); push4(8'hA2, 1'b0); push4(8'hA3, 1'b1);
    run4("short", 1, 20);
    expect4("short_w", 32'h00A3A2A1, 3'd3, 1'b1);

    // Back-pressure: hold fills, three more go into the accumulator, then stall.
    free4 = 0;
    clear_rd4();
    for (int i = 0; i < 12; i++) push4(8'(8'h10 + i), i == 11);
    repeat (20) tick();
    chk("bp_reads",  64'(rd4_cnt), 64'(7));
    chk("bp_writes", 64'(w4_d.size()), 64'(0));
    free4 = 16;
    refresh();
    run4("bp", 3, 40);
    if (w4_cyc.size() >= 2) chk("bp_consec", 64'(w4_cyc[1] - w4_cyc[0]), 64'(1));
    expect4("bp_w0", 32'h13121110, 3'd4, 1'b0);
    expect4("bp_w1", 32'h17161514, 3'd4, 1'b0);
    expect4("bp_w2", 32'h1B1A1918, 3'd4, 1'b1);

    // Single-word packet and last landing on the final lane.
    push4(8'h5C, 1'b1);
    run4("single", 1, 20);
    expect4("single_w", 32'h0000005C, 3'd1, 1'b1);
    for (int i = 0; i < 4; i++) push4(8'(8'h31 + i), i == 3);
    run4("lane3", 1, 20);
    expect4("lane3_w", 32'h34333231, 3'd4, 1'b1);

    // Reset with two lanes loaded discards them.
    clear_rd4();
    push4(8'h71, 1'b0); push4(8'h72, 1'b0);
    tick(); tick();
    chk("mid_reads", 64'(rd4_cnt), 64'(2));
    rst = 1'b1;
    tick();
    chk("mid_in_read",   64'(bus4.in_read),         64'(0));
    chk("mid_out_write", 64'(bus4.out_write),       64'(0));
    chk("mid_data",      64'(bus4.out_write_data),  64'(0));
    chk("mid_count",     64'(bus4.out_write_count), 64'(0));
    chk("mid_last",      64'(bus4.out_write_last),  64'(0));
    rst = 1'b0;
    refresh();
    for (int i = 0; i < 4; i++) push4(8'(8'h81 + i), i == 3);
    run4("post_rst", 1, 20);
    expect4("post_rst_w", 32'h84838281, 3'd4, 1'b1);

    // RATIO=1 unstalled: pass-through with fixed latency.
    q1.push_back({1'b0, 16'h1234});
    q1.push_back({1'b0, 16'hBEEF});
    q1.push_back({1'b1, 16'h0F0F});
    exp1.push_back(16'h1234); exp1.push_back(16'hBEEF); exp1.push_back(16'h0F0F);
    refresh();
    for (int k = 0; k < 20 && w1_d.size() < 3; k++) tick();
    chk("r1_nwrites", 64'(w1_d.size()), 64'(3));
    for (int i = 0; i < 3 && w1_d.size() > 0 && r1_cyc.size() > 0; i++) begin
      chk("r1_data",    64'(w1_d.pop_front()), 64'(exp1.pop_front()));
      chk("r1_count",   64'(w1_c.pop_front()), 64'(1));
      chk("r1_last",    64'(w1_l.pop_front()), 64'(i == 2));
      chk("r1_latency", 64'(w1_cyc.pop_front() - r1_cyc.pop_front()),
          64'(SVNET_FIFO_PACKER_LATENCY));
    end

    // RATIO=1 under random stalls on both sides.
    exp1.delete();
    r1_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      q1.push_back({1'b0, v});
      exp1.push_back(v);
    end
    for (int k = 0; k < 400 && w1_d.size() < 20; k++) begin
      stall1 = ($urandom_range(0, 3) == 0);
      free1  = ($urandom_range(0, 2) == 0) ? 0 : 16;
      refresh();
      tick();
    end
    stall1 = 1'b0;
    free1  = 16;
    refresh();
    chk("r1s_nwrites", 64'(w1_d.size()), 64'(20));
    while (w1_d.size() > 0 && exp1.size() > 0) begin
      chk("r1s_data",  64'(w1_d.pop_front()), 64'(exp1.pop_front()));
      chk("r1s_count", 64'(w1_c.pop_front()), 64'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
